cpu_controller: RTL and testbench

- Fetch/decode/execute sequencer for the 8-bit accumulator CPU; sits directly upstream of the ALU.
- Owns PC, instruction register (IR) and accumulator (ACC); drives ALU opcode and operands; writes ALU result back to ACC.
- Talks to a 16-byte unified memory with synchronous read (1-cycle latency).
- Instruction byte format: [7:4] opcode, [3:0] address or immediate.

---
 rtl/cpu_controller_if.sv | 24 ++
 rtl/cpu_controller.sv | 109 ++++++++++
 tb/tb_cpu_controller.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_controller_if.sv
// Memory and ALU bus between the cpu_controller sequencer and its memory/ALU.
// Latency: none (wires only).
// Backpressure: none; the memory is fixed-latency.
interface cpu_controller_if;
   logic [3:0] mem_addr;
   logic [7:0] mem_rdata;
   logic [7:0] mem_wdata;
   logic       mem_we;
   logic [3:0] alu_opcode;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_result;
   logic       alu_zero;

   modport master (
      output mem_addr, mem_wdata, mem_we, alu_opcode, alu_a, alu_b,
      input  mem_rdata, alu_result, alu_zero
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_we, alu_opcode, alu_a, alu_b,
      output mem_rdata, alu_result, alu_zero
   );
endinterface

// File: rtl/cpu_controller.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU; SINGLE_STEP_EN adds a step gate on FETCH.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXECUTE); HLT parks in HALT until rst.
// Backpressure: none by default; with SINGLE_STEP_EN, FETCH holds until step is high.
module cpu_controller #(
   parameter logic [3:0] RESET_PC = 4'h0
) (
   input  logic             clk,
   input  logic             rst,
`ifdef SINGLE_STEP_EN
   input  logic             step,
`endif
   cpu_controller_if.master bus,
   output logic [7:0]       acc,
   output logic [3:0]       pc,
   output logic             halted
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_DECODE  = 2'd1,
      S_EXECUTE = 2'd2,
      S_HALT    = 2'd3
   } state_t;

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_STA = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_SUB = 4'h4;
   localparam logic [3:0] OP_AND = 4'h5;
   localparam logic [3:0] OP_OR  = 4'h6;
   localparam logic [3:0] OP_JMP = 4'h7;
   localparam logic [3:0] OP_LDI = 4'h8;
   localparam logic [3:0] OP_JZ  = 4'h9;
   localparam logic [3:0] OP_INC = 4'hA;
   localparam logic [3:0] OP_DEC = 4'hB;
   localparam logic [3:0] OP_HLT = 4'hF;

   state_t     state, state_nxt;
   logic [7:0] ir, ir_nxt;
   logic [7:0] acc_nxt;
   logic [3:0] pc_nxt;
   logic       advance;

`ifdef SINGLE_STEP_EN
   assign advance = step;
`else
   assign advance = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FETCH;
         pc    <= RESET_PC;
         acc   <= 8'h00;
         ir    <= 8'h00;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         acc   <= acc_nxt;
         ir    <= ir_nxt;
      end
   end

   assign bus.mem_wdata = acc;
   assign bus.alu_a     = acc;
   assign halted        = (state == S_HALT);

   // mem_we stays combinational so an async reset kills an in-flight store
   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      acc_nxt        = acc;
      ir_nxt         = ir;
      bus.mem_addr   = pc;
      bus.mem_we     = 1'b0;
      bus.alu_opcode = 4'h0;
      bus.alu_b      = 8'h00;
      case (state)
         S_FETCH: begin
            if (advance) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            ir_nxt       = bus.mem_rdata;
            bus.mem_addr = bus.mem_rdata[3:0];
            pc_nxt       = pc + 4'd1;
            state_nxt    = S_EXECUTE;
         end
         S_EXECUTE: begin
            bus.mem_addr   = ir[3:0];
            bus.alu_opcode = ir[7:4];
            bus.alu_b      = bus.mem_rdata;
            state_nxt      = S_FETCH;
            case (ir[7:4])
               OP_LDA: acc_nxt = bus.mem_rdata;
               OP_STA: bus.mem_we = 1'b1;
               OP_ADD, OP_SUB, OP_AND, OP_OR,
               OP_INC, OP_DEC: acc_nxt = bus.alu_result;
               OP_JMP: pc_nxt = ir[3:0];
               OP_LDI: acc_nxt = {4'h0, ir[3:0]};
               OP_JZ:  if (bus.alu_zero) pc_nxt = ir[3:0];
               OP_HLT: state_nxt = S_HALT;
               default: ;
            endcase
         end
         S_HALT: ;
      endcase
   end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: memory + ALU models, directed vector table, ISA-level random reference.
// Latency: checks sampled on the falling edge, inputs driven there too.
// Backpressure: step held high except in the SINGLE_STEP_EN sequence.
module tb_cpu_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic step = 1'b1;
   logic [7:0] acc;
   logic [3:0] pc;
   logic halted;

   cpu_controller_if bus();

   always #5 clk = ~clk;

   cpu_controller #(.RESET_PC(4'h0)) dut (
      .clk    (clk),
      .rst    (rst),
`ifdef SINGLE_STEP_EN
      .step   (step),
`endif
      .bus    (bus),
      .acc    (acc),
      .pc     (pc),
      .halted (halted)
   );

   // Synchronous-read memory, bulk-loaded from img while ld is high
   logic [15:0][7:0] mem;
   logic [15:0][7:0] img;
   logic             ld = 1'b0;

   always @(posedge clk) begin
      if (ld) mem <= img;
      else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   always_comb begin
      case (bus.alu_opcode)
         4'h3: bus.alu_result = bus.alu_a + bus.alu_b;
         4'h4: bus.alu_result = bus.alu_a - bus.alu_b;
         4'h5: bus.alu_result = bus.alu_a & bus.alu_b;
         4'h6: bus.alu_result = bus.alu_a | bus.alu_b;
         4'hA: bus.alu_result = bus.alu_a + 8'd1;
         4'hB: bus.alu_result = bus.alu_a - 8'd1;
         default: bus.alu_result = bus.alu_a;
      endcase
      bus.alu_zero = (bus.alu_result == 8'h00);
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input logic [15:0][7:0] image);
      rst = 1'b1;
      img = image;
      ld  = 1'b1;
      tick(1);
      ld  = 1'b0;
      rst = 1'b0;
   endtask

   typedef struct packed {
      logic [15:0][7:0] img;
      logic [7:0]       cycles;
      logic [3:0]       exp_pc;
      logic [7:0]       exp_acc;
      logic             exp_halted;
   } vec_t;

   function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, be, bf,
                               input logic [7:0] cyc, input logic [3:0] epc,
                               input logic [7:0] eacc, input logic eh);
      vec_t v;
      v.img = '0;
      v.img[0] = b0; v.img[1] = b1; v.img[2] = b2; v.img[3] = b3;
      v.img[14] = be; v.img[15] = bf;
      v.cycles = cyc; v.exp_pc = epc; v.exp_acc = eacc; v.exp_halted = eh;
      return v;
   endfunction

   // ISA-level reference: one call executes a whole instruction
   logic [7:0] m_mem [16];
   logic [3:0] m_pc;
   logic [7:0] m_acc;
   logic       m_halt;

   task automatic model_step();
      logic [7:0] ir;
      logic [7:0] opd;
      logic [3:0] a;
      if (m_halt) return;
      ir   = m_mem[m_pc];
      a    = ir[3:0];
      opd  = m_mem[a];
      m_pc = m_pc + 4'd1;
      case (ir[7:4])
         4'h1: m_acc = opd;
         4'h2: m_mem[a] = m_acc;
         4'h3: m_acc = m_acc + opd;
         4'h4: m_acc = m_acc - opd;
         4'h5: m_acc = m_acc & opd;
         4'h6: m_acc = m_acc | opd;
         4'h7: m_pc = a;
         4'h8: m_acc = {4'h0, a};
         4'h9: if (m_acc == 8'h00) m_pc = a;
         4'hA: m_acc = m_acc + 8'd1;
         4'hB: m_acc = m_acc - 8'd1;
         4'hF: m_halt = 1'b1;
         default: ;
      endcase
   endtask

   vec_t vecs [13];
   logic [15:0][7:0] prog;
   int we_seen;

   initial begin
      vecs[0]  = mk(8'h85, 8'h3E, 8'h2F, 8'hF0, 8'h03, 8'h00, 6,  4'h2, 8'h08, 1'b0);
      vecs[1]  = mk(8'h85, 8'h3E, 8'h2F, 8'hF0, 8'h03, 8'h00, 12, 4'h4, 8'h08, 1'b1);
      vecs[2]  = mk(8'h85, 8'h3E, 8'h2F, 8'hF0, 8'h03, 8'h00, 40, 4'h4, 8'h08, 1'b1);
      vecs[3]  = mk(8'h80, 8'h95, 8'h00, 8'h00, 8'h00, 8'h00, 6,  4'h5, 8'h00, 1'b0);
      vecs[4]  = mk(8'h81, 8'h95, 8'h00, 8'h00, 8'h00, 8'h00, 6,  4'h2, 8'h01, 1'b0);
      vecs[5]  = mk(8'h82, 8'h4E, 8'hA0, 8'hB0, 8'h03, 8'h00, 6,  4'h2, 8'hFF, 1'b0);
      vecs[6]  = mk(8'h82, 8'h4E, 8'hA0, 8'hB0, 8'h03, 8'h00, 9,  4'h3, 8'h00, 1'b0);
      vecs[7]  = mk(8'h82, 8'h4E, 8'hA0, 8'hB0, 8'h03, 8'h00, 12, 4'h4, 8'hFF, 1'b0);
      vecs[8]  = mk(8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 6,  4'h0, 8'h00, 1'b0);
      vecs[9]  = mk(8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 9,  4'hF, 8'h00, 1'b0);
      vecs[10] = mk(8'h70, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 30, 4'h0, 8'h00, 1'b0);
      vecs[11] = mk(8'h87, 8'h2A, 8'h81, 8'h1A, 8'h00, 8'h00, 12, 4'h4, 8'h07, 1'b0);
      vecs[12] = mk(8'h8C, 8'h5E, 8'h6F, 8'h00, 8'h03, 8'h30, 9,  4'h3, 8'h30, 1'b0);

      tick(2);
      prog = vecs[0].img;
      do_reset(prog);
      chk("reset_pc", pc, 4'h0);
      chk("reset_acc", acc, 8'h00);
      chk("reset_halted", halted, 1'b0);
      chk("reset_mem_we", bus.mem_we, 1'b0);
      chk("reset_alu_opcode", bus.alu_opcode, 4'h0);
      chk("reset_mem_addr", bus.mem_addr, 4'h0);

      foreach (vecs[i]) begin
         do_reset(vecs[i].img);
         tick(int'(vecs[i].cycles));
         chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
         chk($sformatf("vec%0d_acc", i), acc, vecs[i].exp_acc);
         chk($sformatf("vec%0d_halted", i), halted, vecs[i].exp_halted);
         chk($sformatf("vec%0d_mem_addr", i), bus.mem_addr, vecs[i].exp_pc);
      end

      // Store timing: exactly one write strobe, during the STA execute cycle
      do_reset(vecs[0].img);
      we_seen = 0;
      for (int n = 0; n < 14; n++) begin
         if (bus.mem_we) we_seen++;
         if (n == 8) begin
            chk("sta_we", bus.mem_we, 1'b1);
            chk("sta_addr", bus.mem_addr, 4'hF);
            chk("sta_wdata", bus.mem_wdata, 8'h08);
         end
         tick(1);
      end
      chk("sta_pulse_count", we_seen, 1);
      chk("sta_mem_written", mem[15], 8'h08);
      for (int n = 0; n < 25; n++) begin
         chk("halt_hold_pc", pc, 4'h4);
         chk("halt_hold_halted", halted, 1'b1);
         chk("halt_hold_we", bus.mem_we, 1'b0);
         tick(1);
      end

      // Async reset landing in the middle of a store aborts it
      do_reset(vecs[0].img);
      tick(8);
      chk("abort_we_before", bus.mem_we, 1'b1);
      rst = 1'b1;
      #1;
      chk("abort_we", bus.mem_we, 1'b0);
      chk("abort_pc", pc, 4'h0);
      chk("abort_acc", acc, 8'h00);
      chk("abort_halted", halted, 1'b0);
      chk("abort_alu_opcode", bus.alu_opcode, 4'h0);
      tick(1);
      rst = 1'b0;
      chk("abort_mem_addr", bus.mem_addr, 4'h0);
      chk("abort_no_write", mem[15], 8'h00);

      // Random programs against the ISA model
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 16; i++) begin
            prog[i]  = 8'($urandom);
            m_mem[i] = prog[i];
         end
         m_pc = 4'h0; m_acc = 8'h00; m_halt = 1'b0;
         do_reset(prog);
         for (int k = 0; k < 30; k++) begin
            model_step();
            tick(3);
            chk($sformatf("rnd%0d_i%0d_pc", r, k), pc, m_pc);
            chk($sformatf("rnd%0d_i%0d_acc", r, k), acc, m_acc);
            chk($sformatf("rnd%0d_i%0d_halted", r, k), halted, m_halt);
         end
         for (int i = 0; i < 16; i++)
            chk($sformatf("rnd%0d_mem%0d", r, i), mem[i], m_mem[i]);
      end

`ifdef SINGLE_STEP_EN
      prog = vecs[0].img;
      step = 1'b0;
      do_reset(prog);
      for (int n = 0; n < 10; n++) begin
         chk("step_idle_pc", pc, 4'h0);
         chk("step_idle_acc", acc, 8'h00);
         chk("step_idle_addr", bus.mem_addr, 4'h0);
         tick(1);
      end
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(2);
      chk("step_one_pc", pc, 4'h1);
      chk("step_one_acc", acc, 8'h05);
      tick(6);
      chk("step_hold_pc", pc, 4'h1);
      chk("step_hold_acc", acc, 8'h05);
      chk("step_hold_addr", bus.mem_addr, 4'h1);
      step = 1'b1;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
